mips_run_sequencer: RTL and testbench
=====================================

Name: mips_run_sequencer

Overview:
- Controller that owns the single-cycle MIPS core's reset and instruction-write path.
- Streams a program from a host into instruction memory over a valid/ready handshake, then holds the core in reset for a fixed number of cycles and releases it.
- Monitors the core's PC and ends the run on a self-loop halt or a cycle budget, then latches Result/PC/cycle count for the host.
- Sits between the bench or host and SingleClockMIPS; drives its RST/WE/W_Ins-side signals.

Parameters:
- ADDR_W, 8, instruction memory word-address width; depth is 2^ADDR_W words.
- RST_CYCLES, 4, number of cycles CORE_RST is held high after loading; must be ≥1.
- CNT_W, 16, width of the run-cycle counter.
- MAX_CYCLES, 65535, run-cycle budget before timeout; must be ≤2^CNT_W-1.
- HALT_REPEAT, 2, number of consecutive equal-PC comparisons that declare a halt; must be ≥1.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  asynchronous, active-low reset.
- LD_VALID  in  1  host offers an instruction word.
- LD_READY  out  1  sequencer accepts a word; transfer occurs when LD_VALID&LD_READY.
- LD_DATA  in  32  instruction word.
- LD_LAST  in  1  marks the final word of the program.
- ACK  in  1  host acknowledge; returns DONE/ERR to IDLE.
- IM_WE  out  1  instruction memory write strobe.
- IM_ADDR  out  ADDR_W  write word address.
- IM_WDATA  out  32  write data.
- CORE_RST  out  1  active-high reset to the core.
- CORE_PC  in  32  core PC.
- CORE_RESULT  in  32  core Result.
- BUSY  out  1  high in HOLD or RUN.
- DONE  out  1  run finished.
- TIMEOUT  out  1  run ended on the cycle budget.
- ERR  out  1  program overflowed instruction memory.
- CYCLES  out  CNT_W  RUN cycles elapsed.
- FINAL_PC  out  32  CORE_PC latched at run end.
- RESULT  out  32  CORE_RESULT latched at run end.

Behaviour:
- States: IDLE, LOAD, HOLD, RUN, DONE, ERROR.
- Reset values: state=IDLE, CORE_RST=1, IM_WE=0, IM_ADDR=0, IM_WDATA=0, LD_READY=1, BUSY=0, DONE=0, TIMEOUT=0, ERR=0, CYCLES=0, FINAL_PC=0, RESULT=0.
- Reset asserted mid-operation: everything returns to the reset values immediately (asynchronous); the core stays held in reset.
- LD_READY=1 only in IDLE and LOAD.
- CORE_RST=1 in IDLE, LOAD, HOLD, DONE and ERROR; CORE_RST=0 only in RUN.
- IDLE, word accepted: write pointer := 0; go to LOAD, or directly to HOLD if LD_LAST=1.
- Write timing: each accepted word produces IM_WE=1, IM_ADDR=pointer, IM_WDATA=LD_DATA in the next cycle (registered, 1-cycle latency). The pointer then increments. IM_WE=0 in every cycle that follows no acceptance.
- LOAD, word accepted with LD_LAST=1: go to HOLD. The final write appears during the first HOLD cycle.
- LOAD, word accepted at pointer 2^ADDR_W-1 with LD_LAST=0: that word is written, then go to ERROR with ERR=1. Further words are refused.
- HOLD entry: CYCLES:=0. Stay RST_CYCLES cycles, then go to RUN.
- RUN:
  - CYCLES increments every cycle; the first RUN cycle yields CYCLES=1.
  - The PC is compared with the previous cycle's PC from the second RUN cycle onward. A run of HALT_REPEAT consecutive equal comparisons is a halt; any mismatch restarts the run.
  - Halt: go to DONE; latch FINAL_PC=CORE_PC and RESULT=CORE_RESULT in the detecting cycle; TIMEOUT=0.
  - CYCLES reaches MAX_CYCLES without a halt: go to DONE with TIMEOUT=1 and the same latching.
  - Halt and timeout in the same cycle: halt wins, TIMEOUT=0.
- DONE/ERROR + ACK: go to IDLE; clear DONE, TIMEOUT and ERR. CYCLES, FINAL_PC and RESULT are retained until the next HOLD entry.
- ACK is ignored in the other states. LD_VALID is ignored outside IDLE and LOAD.

Optional Feature:
- Macro MIPS_SEQ_CHECKSUM_EN.
- Defined: adds output LD_CSUM[31:0], reset 0, cleared on IDLE→LOAD/HOLD. Each accepted word updates csum := {csum[30:0],csum[31]} ^ LD_DATA, visible on the cycle after acceptance.
- Undefined: port and logic are absent; all other behaviour is identical.

Test Plan:
- Load 3 words (0x20080005, 0x21080001, 0x08000002 with LAST on the third) → IM_WE pulses at addresses 0,1,2 one cycle after each handshake. Then CORE_RST high for 4 cycles, then low.
- Core model PC 0,4,8,8,8 with Result=6 → DONE=1 after CYCLES=5, FINAL_PC=8, RESULT=6, CORE_RST=1; ACK → IDLE, DONE=0, RESULT still 6.
- Program whose PC never repeats, MAX_CYCLES=20 → DONE=1, TIMEOUT=1, CYCLES=20.
- ADDR_W=2, 5 words without LAST → 4 writes at addresses 0–3, ERR=1, LD_READY=0; ACK → IDLE with ERR=0.
- RST low during RUN at cycle 7 → all outputs at reset values at once, CORE_RST=1, LD_READY=1.
- With MIPS_SEQ_CHECKSUM_EN, load 0x00000001 then 0x80000000 (LAST) → LD_CSUM=0x00000001, then 0x80000002.

Source files
------------

// File: rtl/mips_run_sequencer_if.sv
// Program-load handshake between the host and mips_run_sequencer.
// The host is the master: it offers words with LD_VALID/LD_DATA/LD_LAST and
// the sequencer answers with LD_READY.
interface mips_run_sequencer_if;
  logic        LD_VALID;
  logic        LD_READY;
  logic [31:0] LD_DATA;
  logic        LD_LAST;

  modport master (output LD_VALID, LD_DATA, LD_LAST, input LD_READY);
  modport slave  (input LD_VALID, LD_DATA, LD_LAST, output LD_READY);
endinterface

// File: rtl/mips_run_sequencer.sv
// mips_run_sequencer: owns the single-cycle MIPS core's reset and
// instruction-write path. It streams a program into instruction memory,
// holds the core in reset for RST_CYCLES cycles, runs it until the PC
// self-loops (halt) or MAX_CYCLES elapse, then latches PC/Result/cycle count.
// Optional: define MIPS_SEQ_CHECKSUM_EN to add the LD_CSUM load checksum port.
module mips_run_sequencer #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned RST_CYCLES  = 4,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned MAX_CYCLES  = 65535,
  parameter int unsigned HALT_REPEAT = 2
) (
  input  logic                 CLK,
  input  logic                 RST,
  mips_run_sequencer_if.slave  ld,
  input  logic                 ACK,
  output logic                 IM_WE,
  output logic [ADDR_W-1:0]    IM_ADDR,
  output logic [31:0]          IM_WDATA,
  output logic                 CORE_RST,
  input  logic [31:0]          CORE_PC,
  input  logic [31:0]          CORE_RESULT,
  output logic                 BUSY,
  output logic                 DONE,
  output logic                 TIMEOUT,
  output logic                 ERR,
  output logic [CNT_W-1:0]     CYCLES,
  output logic [31:0]          FINAL_PC,
  output logic [31:0]          RESULT
`ifdef MIPS_SEQ_CHECKSUM_EN
  ,
  output logic [31:0]          LD_CSUM
`endif
);

  localparam int unsigned HOLD_W = $clog2(RST_CYCLES + 1);
  localparam int unsigned EQ_W   = $clog2(HALT_REPEAT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_HOLD, S_RUN, S_DONE, S_ERROR
  } state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] wr_ptr;
  logic [HOLD_W-1:0] hold_cnt;
  logic [EQ_W-1:0]   eq_cnt;
  logic [31:0]       prev_pc;
  logic              pc_valid;
  logic [CNT_W-1:0]  cycles_inc;
  logic              load_open, accept, hold_done, pc_match, halt, budget_hit;

  assign load_open  = (state == S_IDLE) || (state == S_LOAD);
  assign accept     = ld.LD_VALID && load_open;
  assign hold_done  = (hold_cnt == HOLD_W'(RST_CYCLES - 1));
  assign pc_match   = pc_valid && (CORE_PC == prev_pc);
  assign halt       = pc_match && (eq_cnt == EQ_W'(HALT_REPEAT - 1));
  assign cycles_inc = CYCLES + CNT_W'(1);
  assign budget_hit = (cycles_inc == CNT_W'(MAX_CYCLES));

  // State register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= S_IDLE;
    else      state <= state_nx;
  end

  // Next-state decision.
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (accept) state_nx = ld.LD_LAST ? S_HOLD : S_LOAD;
      S_LOAD:  if (accept) begin
                 if (ld.LD_LAST)         state_nx = S_HOLD;
                 else if (wr_ptr == '1)  state_nx = S_ERROR;
               end
      S_HOLD:  if (hold_done) state_nx = S_RUN;
      S_RUN:   if (halt || budget_hit) state_nx = S_DONE;
      S_DONE,
      S_ERROR: if (ACK) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // State-decoded status and control outputs.
  always_comb begin
    ld.LD_READY = load_open;
    CORE_RST    = (state != S_RUN);
    BUSY        = (state == S_HOLD) || (state == S_RUN);
    DONE        = (state == S_DONE);
    ERR         = (state == S_ERROR);
  end

  // Registered instruction-memory write port, one cycle behind acceptance.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      IM_WE    <= 1'b0;
      IM_ADDR  <= '0;
      IM_WDATA <= '0;
      wr_ptr   <= '0;
    end else begin
      IM_WE <= accept;
      if (accept) begin
        IM_WDATA <= ld.LD_DATA;
        // A word taken in IDLE restarts the program at address 0.
        IM_ADDR  <= (state == S_IDLE) ? '0 : wr_ptr;
        wr_ptr   <= (state == S_IDLE) ? ADDR_W'(1) : wr_ptr + ADDR_W'(1);
      end
    end
  end

  // Reset hold timing, run-cycle counting, halt detection and result latching.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      hold_cnt <= '0;
      eq_cnt   <= '0;
      prev_pc  <= '0;
      pc_valid <= 1'b0;
      CYCLES   <= '0;
      TIMEOUT  <= 1'b0;
      FINAL_PC <= '0;
      RESULT   <= '0;
    end else begin
      unique case (state)
        S_IDLE, S_LOAD: begin
          hold_cnt <= '0;
          eq_cnt   <= '0;
          pc_valid <= 1'b0;
          if (state_nx == S_HOLD) CYCLES <= '0;
        end
        S_HOLD: hold_cnt <= hold_cnt + HOLD_W'(1);
        S_RUN: begin
          CYCLES   <= cycles_inc;
          prev_pc  <= CORE_PC;
          pc_valid <= 1'b1;
          eq_cnt   <= pc_match ? eq_cnt + EQ_W'(1) : '0;
          if (halt || budget_hit) begin
            FINAL_PC <= CORE_PC;
            RESULT   <= CORE_RESULT;
            TIMEOUT  <= !halt;
          end
        end
        S_DONE, S_ERROR: if (ACK) TIMEOUT <= 1'b0;
        default: ;
      endcase
    end
  end

`ifdef MIPS_SEQ_CHECKSUM_EN
  // Rotate-xor checksum over accepted words; the clear on IDLE exit is folded
  // into the first word's update so that word alone seeds the sum.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) LD_CSUM <= '0;
    else if (accept)
      LD_CSUM <= ((state == S_IDLE) ? 32'd0 : {LD_CSUM[30:0], LD_CSUM[31]}) ^ ld.LD_DATA;
  end
`endif

endmodule

// File: tb/tb_mips_run_sequencer.sv
// Self-checking bench for mips_run_sequencer: randomized loads and PC traces
// checked against a behavioural model of the load/hold/run/ack protocol.
module tb_mips_run_sequencer;
  localparam int ADDR_W      = 2;
  localparam int RST_CYCLES  = 4;
  localparam int CNT_W       = 16;
  localparam int MAX_CYCLES  = 20;
  localparam int HALT_REPEAT = 2;
  localparam int DEPTH       = 1 << ADDR_W;

  logic              CLK = 1'b0;
  logic              RST = 1'b0;
  logic              ACK = 1'b0;
  logic              IM_WE;
  logic [ADDR_W-1:0] IM_ADDR;
  logic [31:0]       IM_WDATA;
  logic              CORE_RST;
  logic [31:0]       CORE_PC = '0;
  logic [31:0]       CORE_RESULT = '0;
  logic              BUSY, DONE, TIMEOUT, ERR;
  logic [CNT_W-1:0]  CYCLES;
  logic [31:0]       FINAL_PC, RESULT;
`ifdef MIPS_SEQ_CHECKSUM_EN
  logic [31:0]       LD_CSUM;
`endif

  mips_run_sequencer_if ld_if ();

  mips_run_sequencer #(
    .ADDR_W(ADDR_W), .RST_CYCLES(RST_CYCLES), .CNT_W(CNT_W),
    .MAX_CYCLES(MAX_CYCLES), .HALT_REPEAT(HALT_REPEAT)
  ) dut (
    .CLK(CLK), .RST(RST), .ld(ld_if), .ACK(ACK),
    .IM_WE(IM_WE), .IM_ADDR(IM_ADDR), .IM_WDATA(IM_WDATA),
    .CORE_RST(CORE_RST), .CORE_PC(CORE_PC), .CORE_RESULT(CORE_RESULT),
    .BUSY(BUSY), .DONE(DONE), .TIMEOUT(TIMEOUT), .ERR(ERR),
    .CYCLES(CYCLES), .FINAL_PC(FINAL_PC), .RESULT(RESULT)
`ifdef MIPS_SEQ_CHECKSUM_EN
    , .LD_CSUM(LD_CSUM)
`endif
  );

  always #5 CLK = ~CLK;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] prog [8];
  logic [31:0] pcs  [1:MAX_CYCLES];
  logic [31:0] ress [1:MAX_CYCLES];
  logic [31:0] csum_m = '0;
  int          last_cycles = 0;
  logic [31:0] last_pc = '0;
  logic [31:0] last_res = '0;

  task automatic test_reset();
    RST = 1'b0; ACK = 1'b0;
    ld_if.LD_VALID = 1'b0; ld_if.LD_DATA = '0; ld_if.LD_LAST = 1'b0;
    repeat (2) @(negedge CLK);
    checks++;
    if ({CORE_RST, IM_WE, ld_if.LD_READY, BUSY, DONE, TIMEOUT, ERR} !== 7'b1010000) begin
      errors++;
      $display("FAIL reset_flags: CORE_RST,IM_WE,LD_READY,BUSY,DONE,TIMEOUT,ERR=%b want 1010000",
               {CORE_RST, IM_WE, ld_if.LD_READY, BUSY, DONE, TIMEOUT, ERR});
    end
    checks++;
    if (IM_ADDR !== '0 || IM_WDATA !== '0 || CYCLES !== '0 || FINAL_PC !== '0 || RESULT !== '0) begin
      errors++;
      $display("FAIL reset_data: addr=%h wdata=%h cycles=%0d pc=%h res=%h want all 0",
               IM_ADDR, IM_WDATA, CYCLES, FINAL_PC, RESULT);
    end
    RST = 1'b1;
    @(negedge CLK);
    checks++;
    if (ld_if.LD_READY !== 1'b1 || CORE_RST !== 1'b1 || BUSY !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: LD_READY=%b CORE_RST=%b BUSY=%b want 1 1 0",
               ld_if.LD_READY, CORE_RST, BUSY);
    end
  endtask

  // Streams prog[0..n-1] with random gaps; returns on the cycle after the
  // last word has been offered and its write (if any) checked.
  task automatic load_prog(input int n, input bit use_last);
    int i, ptr, guard, paddr;
    bit pend, rdy, rdy_now;
    logic [31:0] pdata;
    i = 0; ptr = 0; guard = 0; paddr = 0; pend = 1'b0; rdy = 1'b1; pdata = '0;
    while (1) begin
      checks++;
      if (IM_WE !== pend) begin
        errors++; $display("FAIL load_we: IM_WE=%b want %b (offer %0d)", IM_WE, pend, i);
      end
      if (pend) begin
        checks++;
        if (IM_ADDR !== ADDR_W'(paddr) || IM_WDATA !== pdata) begin
          errors++;
          $display("FAIL load_write: addr=%0d data=%h want addr=%0d data=%h", IM_ADDR, IM_WDATA, paddr, pdata);
        end
`ifdef MIPS_SEQ_CHECKSUM_EN
        checks++;
        if (LD_CSUM !== csum_m) begin
          errors++; $display("FAIL load_csum: LD_CSUM=%h want %h", LD_CSUM, csum_m);
        end
`endif
      end
      checks++;
      if (ld_if.LD_READY !== rdy) begin
        errors++; $display("FAIL load_ready: LD_READY=%b want %b (offer %0d)", ld_if.LD_READY, rdy, i);
      end
      pend = 1'b0;
      if (i >= n) break;
      if (guard >= 200) begin
        errors++; $display("FAIL load_budget: %0d of %0d words offered, want all", i, n);
        break;
      end
      rdy_now = rdy;
      if ($urandom_range(0, 3) != 0) begin
        ld_if.LD_VALID = 1'b1;
        ld_if.LD_DATA  = prog[i];
        ld_if.LD_LAST  = use_last && (i == n - 1);
        if (rdy) begin
          pend = 1'b1; paddr = ptr; pdata = prog[i];
          csum_m = ((i == 0) ? 32'h0 : {csum_m[30:0], csum_m[31]}) ^ prog[i];
          if ((use_last && i == n - 1) || ptr == DEPTH - 1) rdy = 1'b0;
          ptr++;
        end
        i++;
      end else begin
        ld_if.LD_VALID = 1'b0;
        ld_if.LD_DATA  = $urandom;
        ld_if.LD_LAST  = 1'($urandom_range(0, 1));
      end
      ACK = rdy_now ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge CLK);
      guard++;
    end
    ld_if.LD_VALID = 1'b0; ld_if.LD_LAST = 1'b0; ACK = 1'b0;
  endtask

  task automatic hold_phase();
    for (int h = 0; h < RST_CYCLES; h++) begin
      checks++;
      if (CORE_RST !== 1'b1 || BUSY !== 1'b1 || ld_if.LD_READY !== 1'b0 || DONE !== 1'b0) begin
        errors++;
        $display("FAIL hold_state: cycle %0d CORE_RST=%b BUSY=%b LD_READY=%b DONE=%b want 1 1 0 0",
                 h, CORE_RST, BUSY, ld_if.LD_READY, DONE);
      end
      checks++;
      if (CYCLES !== '0) begin
        errors++; $display("FAIL hold_cycles: CYCLES=%0d want 0", CYCLES);
      end
      if (h > 0) begin
        checks++;
        if (IM_WE !== 1'b0) begin
          errors++; $display("FAIL hold_we: IM_WE=%b want 0", IM_WE);
        end
      end
      ld_if.LD_VALID = 1'($urandom_range(0, 1));
      ld_if.LD_DATA  = $urandom;
      ACK            = 1'($urandom_range(0, 1));
      @(negedge CLK);
    end
    ld_if.LD_VALID = 1'b0; ACK = 1'b0;
  endtask

  // Plays pcs/ress as the core trace and checks the run outcome.
  task automatic run_phase();
    int run, k_end;
    bit to_exp;
    run = 0; k_end = MAX_CYCLES; to_exp = 1'b0;
    for (int k = 1; k <= MAX_CYCLES; k++) begin
      if (k >= 2 && pcs[k] == pcs[k-1]) run++;
      else run = 0;
      if (run == HALT_REPEAT) begin k_end = k; break; end
      if (k == MAX_CYCLES) to_exp = 1'b1;
    end
    for (int k = 1; k <= k_end; k++) begin
      checks++;
      if (CORE_RST !== 1'b0 || BUSY !== 1'b1 || DONE !== 1'b0 || ld_if.LD_READY !== 1'b0) begin
        errors++;
        $display("FAIL run_state: cycle %0d CORE_RST=%b BUSY=%b DONE=%b LD_READY=%b want 0 1 0 0",
                 k, CORE_RST, BUSY, DONE, ld_if.LD_READY);
      end
      checks++;
      if (CYCLES !== CNT_W'(k - 1)) begin
        errors++; $display("FAIL run_cycles: CYCLES=%0d want %0d", CYCLES, k - 1);
      end
      CORE_PC = pcs[k]; CORE_RESULT = ress[k];
      ACK = 1'($urandom_range(0, 1));
      ld_if.LD_VALID = 1'($urandom_range(0, 1)); ld_if.LD_DATA = $urandom;
      @(negedge CLK);
    end
    ACK = 1'b0; ld_if.LD_VALID = 1'b0;
    checks++;
    if (DONE !== 1'b1 || BUSY !== 1'b0 || CORE_RST !== 1'b1 || TIMEOUT !== to_exp || IM_WE !== 1'b0) begin
      errors++;
      $display("FAIL run_end: DONE=%b BUSY=%b CORE_RST=%b TIMEOUT=%b IM_WE=%b want 1 0 1 %b 0",
               DONE, BUSY, CORE_RST, TIMEOUT, IM_WE, to_exp);
    end
    checks++;
    if (CYCLES !== CNT_W'(k_end) || FINAL_PC !== pcs[k_end] || RESULT !== ress[k_end]) begin
      errors++;
      $display("FAIL run_latch: CYCLES=%0d FINAL_PC=%h RESULT=%h want %0d %h %h",
               CYCLES, FINAL_PC, RESULT, k_end, pcs[k_end], ress[k_end]);
    end
    last_cycles = k_end; last_pc = pcs[k_end]; last_res = ress[k_end];
  endtask

  task automatic ack_phase(input bit expect_err);
    int wait_n;
    wait_n = $urandom_range(0, 3);
    repeat (wait_n) begin
      checks++;
      if (DONE !== !expect_err || ERR !== expect_err) begin
        errors++;
        $display("FAIL ack_wait: DONE=%b ERR=%b want %b %b", DONE, ERR, !expect_err, expect_err);
      end
      @(negedge CLK);
    end
    ACK = 1'b1;
    @(negedge CLK);
    ACK = 1'b0;
    checks++;
    if (DONE !== 1'b0 || ERR !== 1'b0 || TIMEOUT !== 1'b0 || ld_if.LD_READY !== 1'b1 ||
        CORE_RST !== 1'b1 || BUSY !== 1'b0) begin
      errors++;
      $display("FAIL ack_idle: DONE=%b ERR=%b TIMEOUT=%b LD_READY=%b CORE_RST=%b BUSY=%b want 0 0 0 1 1 0",
               DONE, ERR, TIMEOUT, ld_if.LD_READY, CORE_RST, BUSY);
    end
    checks++;
    if (CYCLES !== CNT_W'(last_cycles) || FINAL_PC !== last_pc || RESULT !== last_res) begin
      errors++;
      $display("FAIL ack_retain: CYCLES=%0d FINAL_PC=%h RESULT=%h want %0d %h %h",
               CYCLES, FINAL_PC, RESULT, last_cycles, last_pc, last_res);
    end
  endtask

  task automatic test_load_and_halt();
    prog[0] = 32'h20080005; prog[1] = 32'h21080001; prog[2] = 32'h08000002;
    load_prog(3, 1'b1);
    hold_phase();
    for (int k = 1; k <= MAX_CYCLES; k++) begin
      pcs[k] = (k <= 3) ? 32'((k - 1) * 4) : 32'd8;
      ress[k] = 32'd6;
    end
    run_phase();
    ack_phase(1'b0);
  endtask

  task automatic test_timeout();
    int n;
    logic [31:0] base;
    n = $urandom_range(1, DEPTH);
    for (int w = 0; w < n; w++) prog[w] = $urandom;
    load_prog(n, 1'b1);
    hold_phase();
    base = $urandom & 32'hFFFF_0000;
    for (int k = 1; k <= MAX_CYCLES; k++) begin
      pcs[k] = base + 32'(k * 4); ress[k] = $urandom;
    end
    run_phase();
    ack_phase(1'b0);
  endtask

  task automatic test_halt_at_budget();
    prog[0] = $urandom;
    load_prog(1, 1'b1);
    hold_phase();
    for (int k = 1; k <= MAX_CYCLES; k++) begin
      pcs[k] = (k <= MAX_CYCLES - 2) ? 32'(k * 4) : 32'((MAX_CYCLES - 2) * 4);
      ress[k] = $urandom;
    end
    run_phase();
    ack_phase(1'b0);
  endtask

  task automatic test_overflow();
    for (int w = 0; w < DEPTH + 1; w++) prog[w] = $urandom;
    load_prog(DEPTH + 1, 1'b0);
    checks++;
    if (ERR !== 1'b1 || ld_if.LD_READY !== 1'b0 || BUSY !== 1'b0 || DONE !== 1'b0 || CORE_RST !== 1'b1) begin
      errors++;
      $display("FAIL overflow_state: ERR=%b LD_READY=%b BUSY=%b DONE=%b CORE_RST=%b want 1 0 0 0 1",
               ERR, ld_if.LD_READY, BUSY, DONE, CORE_RST);
    end
    ld_if.LD_VALID = 1'b1; ld_if.LD_DATA = $urandom;
    repeat (2) @(negedge CLK);
    ld_if.LD_VALID = 1'b0;
    checks++;
    if (IM_WE !== 1'b0 || ERR !== 1'b1) begin
      errors++; $display("FAIL overflow_refuse: IM_WE=%b ERR=%b want 0 1", IM_WE, ERR);
    end
    ack_phase(1'b1);
  endtask

  task automatic test_back_to_back();
    int n;
    for (int it = 0; it < 8; it++) begin
      n = $urandom_range(1, DEPTH);
      for (int w = 0; w < n; w++) prog[w] = $urandom;
      load_prog(n, 1'b1);
      hold_phase();
      for (int k = 1; k <= MAX_CYCLES; k++) begin
        pcs[k] = 32'($urandom_range(0, 2) * 4); ress[k] = $urandom;
      end
      run_phase();
      ack_phase(1'b0);
    end
  endtask

  task automatic test_checksum();
`ifdef MIPS_SEQ_CHECKSUM_EN
    prog[0] = 32'h00000001; prog[1] = 32'h80000000;
    load_prog(2, 1'b1);
    checks++;
    if (LD_CSUM !== 32'h80000002) begin
      errors++; $display("FAIL csum_final: LD_CSUM=%h want 80000002", LD_CSUM);
    end
    hold_phase();
    for (int k = 1; k <= MAX_CYCLES; k++) begin pcs[k] = 32'h40; ress[k] = 32'h7; end
    run_phase();
    ack_phase(1'b0);
`endif
  endtask

  task automatic test_reset_mid_run();
    prog[0] = $urandom; prog[1] = $urandom;
    load_prog(2, 1'b1);
    hold_phase();
    for (int k = 1; k <= 6; k++) begin
      CORE_PC = 32'h100 + 32'(k * 4); CORE_RESULT = $urandom;
      @(negedge CLK);
    end
    checks++;
    if (CYCLES !== CNT_W'(6) || CORE_RST !== 1'b0) begin
      errors++; $display("FAIL midrun_pre: CYCLES=%0d CORE_RST=%b want 6 0", CYCLES, CORE_RST);
    end
    RST = 1'b0;
    #1;
    checks++;
    if ({CORE_RST, IM_WE, ld_if.LD_READY, BUSY, DONE, TIMEOUT, ERR} !== 7'b1010000) begin
      errors++;
      $display("FAIL midrun_flags: CORE_RST,IM_WE,LD_READY,BUSY,DONE,TIMEOUT,ERR=%b want 1010000",
               {CORE_RST, IM_WE, ld_if.LD_READY, BUSY, DONE, TIMEOUT, ERR});
    end
    checks++;
    if (IM_ADDR !== '0 || IM_WDATA !== '0 || CYCLES !== '0 || FINAL_PC !== '0 || RESULT !== '0) begin
      errors++;
      $display("FAIL midrun_data: addr=%h wdata=%h cycles=%0d pc=%h res=%h want all 0",
               IM_ADDR, IM_WDATA, CYCLES, FINAL_PC, RESULT);
    end
    csum_m = '0; last_cycles = 0; last_pc = '0; last_res = '0;
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    checks++;
    if (ld_if.LD_READY !== 1'b1 || CORE_RST !== 1'b1 || BUSY !== 1'b0 || DONE !== 1'b0) begin
      errors++;
      $display("FAIL midrun_idle: LD_READY=%b CORE_RST=%b BUSY=%b DONE=%b want 1 1 0 0",
               ld_if.LD_READY, CORE_RST, BUSY, DONE);
    end
  endtask

  initial begin
    test_reset();
    test_load_and_halt();
    test_timeout();
    test_halt_at_budget();
    test_overflow();
    test_checksum();
    test_back_to_back();
    test_reset_mid_run();
    test_load_and_halt();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end
endmodule
